leg4_uart_loader: RTL
=====================

// Module: leg4_uart_loader
// PURPOSE
//  Writable 16x8 program memory for the leg4 CPU, loaded over a UART serial line.
//  Drop-in upstream replacement for the fixed program ROM: same 4-bit address in, 8-bit instruction out.
//  Holds the CPU in reset while a program is being downloaded, then releases it.
// PARAMETERS
//  CLK_HZ       27_000_000  system clock frequency
//  BAUD         115_200     UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer divide, 234 at defaults)
//  SYNC_BYTE    8'hA5       header byte that starts a download
//  TIMEOUT_CLKS 27_000_000  max idle clocks between bytes inside a download (1 s)
// PORTS
//  clk       in   1  system clock, all logic on rising edge
//  nrst      in   1  asynchronous active-low reset
//  uart_rx   in   1  serial input, 8N1, LSB first, idle high
//  address   in   4  CPU fetch address
//  out       out  8  instruction at mem[address], combinational read
//  cpu_nrst  out  1  registered active-low reset to CPU; 0 while loading or in error
//  loading   out  1  1 from sync accepted until last byte handled
//  load_done out  1  1 after a successful download, cleared on next sync
//  load_err  out  1  1 after framing/timeout/checksum error, cleared on next sync
// BEHAVIOUR
//  Reset (nrst=0): mem all 8'h00; cpu_nrst=0, loading=0, load_done=0, load_err=0; FSM=IDLE, RX=R_IDLE.
//  First clk after nrst release: cpu_nrst=1.
//  RX: uart_rx passes a 2-flop synchroniser (reset value 1).
//   - R_IDLE: falling edge -> R_START.
//   - R_START: sample at CLKS_PER_BIT/2; still 0 -> R_DATA, else back to R_IDLE (glitch).
//   - R_DATA: 8 samples, each CLKS_PER_BIT apart, LSB first.
//   - R_STOP: sample; 1 -> rx_valid pulses 1 clk with rx_byte; 0 -> frame_err pulses 1 clk.
//   - After the stop sample, RX returns to R_IDLE and can detect the next start bit immediately.
//  Loader FSM:
//   - IDLE:
//     - rx_valid && rx_byte==SYNC_BYTE -> LOAD: widx=0, loading=1, cpu_nrst=0, load_done=0, load_err=0.
//     - Other bytes and frame errors in IDLE are ignored.
//   - LOAD:
//     - Each rx_valid writes mem[widx]<=rx_byte on that clk edge; widx++.
//     - Bytes equal to SYNC_BYTE are plain data in LOAD.
//     - Write of widx==15 -> FINISH (or CHECK when CHECKSUM_EN is defined).
//   - FINISH (1 clk): loading=0, load_done=1, cpu_nrst=1 -> IDLE.
//     - cpu_nrst rises 2 clks after the last rx_valid.
//   - ERROR (entered from LOAD/CHECK): loading=0, load_err=1, cpu_nrst held 0 -> IDLE.
//     - cpu_nrst stays 0 until a later download succeeds or nrst is asserted.
//  Error causes while loading:
//   - frame_err -> ERROR, byte not written.
//   - Idle counter reaches TIMEOUT_CLKS with no rx_valid -> ERROR. Counter resets on each rx_valid and on LOAD entry.
//  Partial data already written stays in mem (not rolled back).
//  widx is 4 bits and never wraps inside a load; exactly 16 writes per download.
//  Simultaneous: a write and a CPU read of the same address in one clk -> out shows the old byte until the edge.
//  nrst mid-download: immediate abort, mem cleared, all outputs to reset values.
// CONFIGURATION
//  LEG4_LOADER_CHECKSUM_EN defined:
//   - LOAD accumulates an 8-bit wrapping sum of the 16 data bytes.
//   - CHECK waits for byte 17: equals the sum -> FINISH; differs -> ERROR.
//   - Timeout and frame errors also apply in CHECK.
//  Not defined: no CHECK state; FINISH follows byte 16.
// TESTING
//  T1 reset: nrst low, any address -> out=00, cpu_nrst=0; 1 clk after release cpu_nrst=1, flags 0.
//  T2 load: send A5 then 00..0F (234-clk bits) -> loading 1 during the download, mem[k]=k, load_done=1, cpu_nrst=1 2 clks after the last stop bit.
//  T3 ignore: send 3C, then a 0.3-bit low glitch in IDLE -> no state change, mem unchanged.
//  T4 frame error: A5, 5 bytes, then a byte with stop=0 -> load_err=1, cpu_nrst=0, mem[0..4] written, mem[5..15] old.
//  T5 timeout: A5 plus 3 bytes, then line idle -> load_err at exactly TIMEOUT_CLKS; a later good load clears it and releases the CPU.
//  T6 checksum (LEG4_LOADER_CHECKSUM_EN): A5, 00..0F, then 78 -> load_done=1; repeat with 79 -> load_err=1, cpu_nrst=0.

Source files
------------

// File: rtl/leg4_uart_loader.sv
// leg4_uart_loader: UART-loaded 16x8 program memory that holds the leg4 CPU in reset while downloading.
// Optional LEG4_LOADER_CHECKSUM_EN adds a trailing 8-bit sum byte that is checked before the CPU is released.
module leg4_uart_loader #(
    parameter int          CLK_HZ       = 27_000_000,
    parameter int          BAUD         = 115_200,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int          TIMEOUT_CLKS = 27_000_000
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       uart_rx,
    input  logic [3:0] address,
    output logic [7:0] out,
    output logic       cpu_nrst,
    output logic       loading,
    output logic       load_done,
    output logic       load_err
);
    localparam int CPB = CLK_HZ / BAUD;
    localparam int CW  = $clog2(CPB + 1);
    localparam int TW  = $clog2(TIMEOUT_CLKS + 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {
        IDLE, LOAD,
`ifdef LEG4_LOADER_CHECKSUM_EN
        CHECK,
`endif
        FINISH, ERROR
    } state_t;

    logic [1:0]    sync;
    logic          rx_s, rx_prev;
    rx_state_t     rx_state, rx_next;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    rx_byte;
    logic          rx_valid, frame_err;
    logic          tick, tick_half;

    state_t        state, state_n;
    logic [3:0]    widx;
    logic [TW-1:0] idle_cnt;
    logic [7:0]    mem [16];
    logic          loading_n, done_n, err_n, we, timeout;
`ifdef LEG4_LOADER_CHECKSUM_EN
    logic [7:0]    sum;
`endif

    assign rx_s      = sync[1];
    assign tick      = cnt == CW'(CPB - 1);
    assign tick_half = cnt == CW'(CPB / 2 - 1);
    assign out       = mem[address];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync    <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            sync    <= {sync[0], uart_rx};
            rx_prev <= rx_s;
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            R_IDLE:  rx_next = (rx_prev && !rx_s) ? R_START : R_IDLE;
            R_START: rx_next = tick_half ? (rx_s ? R_IDLE : R_DATA) : R_START;
            R_DATA:  rx_next = (tick && bit_idx == 3'd7) ? R_STOP : R_DATA;
            R_STOP:  rx_next = tick ? R_IDLE : R_STOP;
            default: rx_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_state  <= R_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_state  <= rx_next;
            rx_valid  <= rx_state == R_STOP && tick && rx_s;
            frame_err <= rx_state == R_STOP && tick && !rx_s;
            cnt       <= (rx_state == R_IDLE || rx_next != rx_state || (rx_state == R_DATA && tick)) ? '0 : cnt + 1'b1;
            if (rx_state == R_DATA && tick) begin
                rx_byte <= {rx_s, rx_byte[7:1]};
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

    // Expiry is checked one count early so ERROR is entered TIMEOUT_CLKS clocks after the last byte.
    assign timeout = idle_cnt == TW'(TIMEOUT_CLKS - 1) && !rx_valid;

    always_comb begin
        state_n   = state;
        loading_n = loading;
        done_n    = load_done;
        err_n     = load_err;
        we        = 1'b0;
        case (state)
            IDLE: if (rx_valid && rx_byte == SYNC_BYTE) begin
                state_n   = LOAD;
                loading_n = 1'b1;
                done_n    = 1'b0;
                err_n     = 1'b0;
            end
            LOAD: if (frame_err || timeout) state_n = ERROR;
                  else if (rx_valid) begin
                      we = 1'b1;
`ifdef LEG4_LOADER_CHECKSUM_EN
                      state_n = (widx == 4'hF) ? CHECK : LOAD;
`else
                      state_n = (widx == 4'hF) ? FINISH : LOAD;
`endif
                  end
`ifdef LEG4_LOADER_CHECKSUM_EN
            CHECK: if (frame_err || timeout) state_n = ERROR;
                   else if (rx_valid) state_n = (rx_byte == sum) ? FINISH : ERROR;
`endif
            FINISH: begin
                state_n   = IDLE;
                loading_n = 1'b0;
                done_n    = 1'b1;
            end
            ERROR: begin
                state_n   = IDLE;
                loading_n = 1'b0;
                err_n     = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            widx      <= '0;
            idle_cnt  <= '0;
            loading   <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            cpu_nrst  <= 1'b0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
`ifdef LEG4_LOADER_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            state     <= state_n;
            loading   <= loading_n;
            load_done <= done_n;
            load_err  <= err_n;
            cpu_nrst  <= !loading_n && !err_n;
            idle_cnt  <= (state_n == IDLE || state == IDLE || rx_valid) ? '0 : idle_cnt + 1'b1;
            if (we) begin
                mem[widx] <= rx_byte;
                widx      <= widx + 1'b1;
            end else if (state == IDLE) begin
                widx <= '0;
            end
`ifdef LEG4_LOADER_CHECKSUM_EN
            if (state == IDLE) sum <= '0;
            else if (we)       sum <= sum + rx_byte;
`endif
        end
    end
endmodule
